camera_raw_framer: RTL
======================

# camera_raw_framer

Front-end stage of the HDR video pipeline. Converts the sensor's parallel raw Bayer bus (per-pixel data qualified by `cam_href`, frame-delimited by `cam_vsync`) into the framed raw stream (`raw_data`/`raw_valid`/`raw_sop`/`raw_eop`) consumed directly by the bilinear raw-to-RGB interpolator. Guarantees exactly `V_ACTIVE` lines per frame, each line bracketed by one SOP and one EOP, and reports protocol errors on status outputs.

## Interface
- `DATA_WIDTH`, 8: raw pixel width.
- `H_ACTIVE`, 1280: expected pixels per line.
- `V_ACTIVE`, 720: lines forwarded per frame (must match downstream line count).
- `clk`  in  1  pixel clock; all inputs synchronous to it.
- `reset`  in  1  asynchronous, active-high reset.
- `cam_data`  in  DATA_WIDTH  sensor pixel.
- `cam_href`  in  1  high while line pixels are valid, one pixel per cycle.
- `cam_vsync`  in  1  active-high frame pulse; rising edge = frame start.
- `raw_data`  out  DATA_WIDTH  pixel to interpolator.
- `raw_valid`  out  1  pixel qualifier.
- `raw_sop`  out  1  first pixel of line (with `raw_valid`).
- `raw_eop`  out  1  last pixel of line (with `raw_valid`).
- `frame_start`  out  1  one-cycle pulse on accepted vsync rise.
- `frame_done`  out  1  one-cycle pulse with EOP of line `V_ACTIVE`.
- `line_len_err`  out  1  sticky: line length ≠ `H_ACTIVE`; cleared on `frame_start`.
- `frame_err`  out  1  sticky: short frame or vsync during href; cleared only by reset.

## Operation
- Input stage s1 registers `cam_data`, `cam_href` every cycle; `s1_valid = s1_href & line_en`.
- Output registers: `raw_valid <= s1_valid`; `raw_data <= s1_data`; `raw_sop <= s1_valid & ~s1_valid_d`; `raw_eop <= s1_valid & ~(cam_href & line_en)`.
- `line_en`: set on `cam_href` rising edge while state is ACTIVE; cleared when `cam_href` low. An href already high on entry to ACTIVE is masked until it falls (no partial lines).
- FSM, 2-bit state:
  - IDLE (reset state): all href ignored; vsync rising edge -> ACTIVE, pulse `frame_start`.
  - ACTIVE: forward lines; `line_cnt` (12 bit) increments on each emitted EOP; EOP with `line_cnt == V_ACTIVE-1` -> DONE, pulse `frame_done`.
  - DONE: href ignored; vsync rising edge -> ACTIVE, `frame_start`, `line_cnt` <= 0.
- vsync rise in ACTIVE (short frame): set `frame_err`, `line_cnt` <= 0, pulse `frame_start`, stay ACTIVE.
- vsync rise while `line_en`: set `frame_err`; line in flight completes with EOP and counts toward the new frame.
- `pix_cnt` (12 bit) counts forwarded pixels per line, clears at SOP; EOP with `pix_cnt+1 ≠ H_ACTIVE` sets `line_len_err`.
- Simultaneous vsync edge and `frame_done` EOP: `frame_done` pulses, then state goes directly to ACTIVE with `frame_start`.

## Timing
- Latency: `cam_data` to `raw_data` is 2 cycles; SOP aligned with the first pixel and EOP with the last.
- Minimum line: 1 pixel (SOP and EOP in the same cycle).
- href gap ≥1 cycle ends a line.
- No backpressure; downstream always accepts.
- Reset: all outputs 0, state IDLE, counters 0, sticky flags 0. Reset mid-line truncates the line with no EOP; downstream is reset with it.

## Configuration
- `CAMERA_RAW_FRAMER_TRUNC_EN` defined: the pixel with `pix_cnt == H_ACTIVE-1` is forced EOP and the rest of that href is dropped (`line_en` cleared). Long lines are emitted as exactly `H_ACTIVE` pixels and still set `line_len_err`.
- Not defined: all href pixels are forwarded. Length errors are flagged only.

## Structure
- Shared package `raw_pipe_pkg`: state enum `framer_state_t` (IDLE, ACTIVE, DONE), default `H_ACTIVE`/`V_ACTIVE` constants shared with the interpolator's line count.
- One sub-module, `edge_detect`, instantiated for the vsync and href rising edges: registered input, one-cycle rise pulse.

## Test plan
- Reset, then vsync, then 720 lines of 1280 pixels: 720 SOP/EOP pairs, 921600 valids, `frame_done` on the 720th EOP, no error flags.
- 722 lines after one vsync: only the first 720 forwarded; lines 721–722 produce no valid.
- Href high at reset release, then vsync mid-line: masked line yields no output; the next full line starts with SOP.
- Vsync after 300 lines: `frame_err`=1, `frame_start` pulse, the following 720 lines forwarded, `frame_done` on line 720 of the new frame.
- 1283-pixel line: with TRUNC_EN, 1280 valids, EOP on pixel 1280, `line_len_err`=1. Without it, 1283 valids, `line_len_err`=1.
- 1-pixel line, then a 1-cycle href gap, then a 1280-pixel line: first line has SOP=EOP in the same cycle; second line is correct; `line_len_err`=1 and is cleared at the next `frame_start`.

Source files
------------

// File: rtl/raw_pipe_pkg.sv
// Shared definitions for the raw video pipeline: framer state encoding and the
// default frame geometry that the interpolator's line count must agree with.
package raw_pipe_pkg;

  localparam int RAW_H_ACTIVE = 1280;
  localparam int RAW_V_ACTIVE = 720;
  localparam int RAW_CNT_W    = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } framer_state_t;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector: registers the input and pulses rise for the one cycle
// where the input is high but its registered copy is still low.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic sig_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sig_reg <= 1'b0;
    end else begin
      sig_reg <= sig;
    end
  end

  assign rise = sig & ~sig_reg;

endmodule

// File: rtl/camera_raw_framer.sv
// Sensor parallel Bayer bus to framed raw stream (SOP/EOP per line, V_ACTIVE lines
// per frame). Define CAMERA_RAW_FRAMER_TRUNC_EN to cut long lines at H_ACTIVE pixels.
module camera_raw_framer
  import raw_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int H_ACTIVE   = RAW_H_ACTIVE,
  parameter int V_ACTIVE   = RAW_V_ACTIVE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] cam_data,
  input  logic                  cam_href,
  input  logic                  cam_vsync,
  output logic [DATA_WIDTH-1:0] raw_data,
  output logic                  raw_valid,
  output logic                  raw_sop,
  output logic                  raw_eop,
  output logic                  frame_start,
  output logic                  frame_done,
  output logic                  line_len_err,
  output logic                  frame_err
);

  localparam logic [RAW_CNT_W-1:0] H_LAST = RAW_CNT_W'(H_ACTIVE - 1);
  localparam logic [RAW_CNT_W-1:0] V_LAST = RAW_CNT_W'(V_ACTIVE - 1);

  framer_state_t          state_reg, state_next;
  logic [RAW_CNT_W-1:0]   line_cnt_reg, line_cnt_next;
  logic [RAW_CNT_W-1:0]   pix_cnt_reg;
  logic                   line_en_reg, line_en_next;
  logic [DATA_WIDTH-1:0]  s1_data_reg;
  logic                   s1_href_reg;
  logic                   s1_valid_d_reg;

  logic                   vsync_rise, href_rise;
  logic                   s1_valid, sop_s1, eop_s1, trunc_hit, href_cont;
  logic                   final_eop, len_bad, short_frame;
  logic [RAW_CNT_W-1:0]   cur_idx;

  edge_detect u_vsync_edge (.clk(clk), .reset(reset), .sig(cam_vsync), .rise(vsync_rise));
  edge_detect u_href_edge  (.clk(clk), .reset(reset), .sig(cam_href),  .rise(href_rise));

  assign s1_valid  = s1_href_reg & line_en_reg;
  assign sop_s1    = s1_valid & ~s1_valid_d_reg;
  assign cur_idx   = sop_s1 ? '0 : pix_cnt_reg;
  // The pixel behind the one in s1 decides whether s1 holds the last of the line.
  assign href_cont = cam_href & line_en_reg;

`ifdef CAMERA_RAW_FRAMER_TRUNC_EN
  assign trunc_hit = s1_valid & (cur_idx == H_LAST);
`else
  assign trunc_hit = 1'b0;
`endif

  assign eop_s1      = s1_valid & (~href_cont | trunc_hit);
  // A truncated line that still has pixels pending was too long.
  assign len_bad     = eop_s1 & ((cur_idx != H_LAST) | href_cont);
  assign final_eop   = eop_s1 & (state_reg == ACTIVE) & (line_cnt_reg == V_LAST);
  assign short_frame = vsync_rise & (state_reg == ACTIVE) & ~final_eop;

  always_comb begin
    line_en_next = line_en_reg;
    if (!cam_href || trunc_hit) begin
      line_en_next = 1'b0;
    end else if (href_rise && (state_reg == ACTIVE)) begin
      line_en_next = 1'b1;
    end
  end

  always_comb begin
    state_next    = state_reg;
    line_cnt_next = line_cnt_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (vsync_rise) begin
          state_next    = ACTIVE;
          line_cnt_next = '0;
        end
      end
      ACTIVE: begin
        if (vsync_rise) begin
          // A line still in flight will count toward the new frame at its EOP.
          line_cnt_next = '0;
        end else begin
          if (eop_s1) begin
            line_cnt_next = line_cnt_reg + RAW_CNT_W'(1);
          end
          if (final_eop) begin
            state_next = DONE;
          end
        end
      end
      default: begin
        state_next    = IDLE;
        line_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      line_cnt_reg   <= '0;
      pix_cnt_reg    <= '0;
      line_en_reg    <= 1'b0;
      s1_data_reg    <= '0;
      s1_href_reg    <= 1'b0;
      s1_valid_d_reg <= 1'b0;
      raw_data       <= '0;
      raw_valid      <= 1'b0;
      raw_sop        <= 1'b0;
      raw_eop        <= 1'b0;
      frame_start    <= 1'b0;
      frame_done     <= 1'b0;
      line_len_err   <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      line_cnt_reg   <= line_cnt_next;
      line_en_reg    <= line_en_next;
      s1_data_reg    <= cam_data;
      s1_href_reg    <= cam_href;
      s1_valid_d_reg <= s1_valid;
      if (s1_valid) begin
        pix_cnt_reg <= cur_idx + RAW_CNT_W'(1);
      end
      raw_data    <= s1_data_reg;
      raw_valid   <= s1_valid;
      raw_sop     <= sop_s1;
      raw_eop     <= eop_s1;
      frame_start <= vsync_rise;
      frame_done  <= final_eop;
      // An error found on the frame-start cycle is kept rather than lost.
      if (len_bad) begin
        line_len_err <= 1'b1;
      end else if (vsync_rise) begin
        line_len_err <= 1'b0;
      end
      if (short_frame) begin
        frame_err <= 1'b1;
      end
    end
  end

endmodule
